seq_divider: RTL

Sequential restoring divider, the inverse of the team's 3x3 combinational multiplier. It divides an unsigned DW-bit dividend (a multiplier product) by an unsigned VW-bit divisor and returns the quotient and remainder. It produces one quotient bit per clock and uses a start/busy/done handshake. It sits downstream of the multiplier, so arithmetic round trips (A*B)/B can be checked in hardware.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_step.sv | 21 ++
 rtl/seq_divider.sv | 115 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

   localparam int DW_DEF = 6;
   localparam int VW_DEF = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor if it fits.
module div_step #(
   parameter int VW = 3
) (
   input  logic [VW-1:0] r,
   input  logic          d_msb,
   input  logic [VW-1:0] v,
   output logic [VW-1:0] r_next,
   output logic          q_bit
);

   // The trial value needs one extra bit. Since r < v, the result always
   // fits back into VW bits.
   logic [VW:0] t;

   assign t      = {r, d_msb};
   assign q_bit  = (t >= {1'b0, v});
   assign r_next = q_bit ? VW'(t - {1'b0, v}) : t[VW-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, with a
// start/busy/done handshake.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [DW-1:0] DZ_QUOTIENT = '1;

   state_t        state, state_nx;
   logic [DW-1:0] d_sr;
   logic [VW-1:0] v_reg;
   logic [VW-1:0] r_reg;
   logic [DW-1:0] q_sr;
   logic [CW-1:0] cnt;

   logic          accept, step, last;
   logic [VW-1:0] r_nx;
   logic          q_bit;
   logic [DW-1:0] q_nx;

   div_step #(.VW(VW)) u_step (
      .r      (r_reg),
      .d_msb  (d_sr[DW-1]),
      .v      (v_reg),
      .r_next (r_nx),
      .q_bit  (q_bit)
   );

   assign q_nx = DW'({q_sr, q_bit});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // DONE accepts a new start exactly like IDLE, so back-to-back ops need no bubble.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = (divisor == '0) ? DONE : RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CW'(DW - 1)) begin
               last     = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_sr        <= '0;
         v_reg       <= '0;
         r_reg       <= '0;
         q_sr        <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         d_sr  <= dividend;
         v_reg <= divisor;
         r_reg <= '0;
         q_sr  <= '0;
         cnt   <= '0;
         // A zero divisor skips RUN, so its results land on this same edge.
         if (divisor == '0) begin
            quotient    <= DZ_QUOTIENT;
            remainder   <= '0;
            div_by_zero <= 1'b1;
         end
      end else if (step) begin
         d_sr  <= {d_sr[DW-2:0], 1'b0};
         r_reg <= r_nx;
         q_sr  <= q_nx;
         cnt   <= cnt + 1'b1;
         if (last) begin
            quotient    <= q_nx;
            remainder   <= r_nx;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule
